// File: rtl/cpu_controller_pkg.sv
// Shared types for the accumulator CPU sequencer: opcodes, FSM state encodings and the ALU-op helper.
package cpu_controller_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    PAUSE      = 4'd9
  } ctrl_state_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_ctrl_decode.sv
// Combinational strobe decode for the sequencer: registered state plus opcode and zero flag in, strobes out.
module ctrl_decode
  import cpu_controller_pkg::*;
(
  input  ctrl_state_t state,
  input  opcode_t     opcode,
  input  logic        zero,
  output logic        sel,
  output logic        rd,
  output logic        ld_ir,
  output logic        inc_pc,
  output logic        ld_pc,
  output logic        ld_ac,
  output logic        wr,
  output logic        data_e,
  output logic        halt
);

  logic alu_op;

  always_comb begin
    alu_op = is_aluop(opcode);
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    unique case (state)
      INST_ADDR:  sel = 1'b1;
      INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
      INST_LOAD,
      IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
      OP_ADDR: begin
        inc_pc = (opcode != HLT);
        halt   = (opcode == HLT);
      end
      OP_FETCH:   rd = alu_op;
      ALU_OP: begin
        rd     = alu_op;
        inc_pc = (opcode == SKZ) && zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      STORE: begin
        rd     = alu_op;
        inc_pc = (opcode == JMP);
        ld_pc  = (opcode == JMP);
        ld_ac  = alu_op;
        data_e = (opcode == STO);
        wr     = (opcode == STO);
      end
      HALTED:     halt = 1'b1;
      PAUSE:      sel = 1'b1;
      default:    sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU with memory wait states and timeout halt.
// Optional CTRL_SINGLE_STEP_EN adds step_mode/step inputs and a PAUSE state after STORE.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  input  opcode_t    opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic       err,
  output logic [3:0] phase
);

  localparam int WAIT_CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT);

  ctrl_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  err_q, err_d;
  logic                  stall_state;

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    err_d       = err_q;
    stall_state = (state_q == INST_FETCH) || ((state_q == OP_FETCH) && is_aluop(opcode));
    if (stall_state && !mem_ready) begin
      // The counter value equals the stall cycles already spent; one more miss at the limit times out.
      if (wait_q == WAIT_LAST) begin
        state_d = HALTED;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        INST_ADDR:  state_d = INST_FETCH;
        INST_FETCH: state_d = INST_LOAD;
        INST_LOAD:  state_d = IDLE;
        IDLE:       state_d = OP_ADDR;
        OP_ADDR:    state_d = (opcode == HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   state_d = ALU_OP;
        ALU_OP:     state_d = STORE;
`ifdef CTRL_SINGLE_STEP_EN
        STORE:      state_d = step_mode ? PAUSE : INST_ADDR;
        PAUSE:      state_d = step ? INST_ADDR : PAUSE;
`else
        STORE:      state_d = INST_ADDR;
        PAUSE:      state_d = INST_ADDR;
`endif
        HALTED:     state_d = HALTED;
        default:    state_d = INST_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INST_ADDR;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  assign err   = err_q;
  assign phase = state_q;

endmodule
